// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - packs a 64-bit big-endian byte stream into padded 512-bit SHA-1 chunks.
// Optional length-overflow detection with a DROP state: define SHA1_PADDER_LEN_CHECK_EN.
module sha1_padder #(
    parameter int LEN_W = 16
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [63:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         in_ready,
    input  logic         sink_ready,
    output logic         start,
    output logic [511:0] chunk,
    output logic         chunk_first,
    output logic         chunk_last,
    output logic         len_err
);

`ifdef SHA1_PADDER_LEN_CHECK_EN
    typedef enum logic [1:0] {S_DATA, S_PAD, S_EMIT, S_DROP} state_t;
`else
    typedef enum logic [1:0] {S_DATA, S_PAD, S_EMIT} state_t;
`endif

    localparam logic [63:0] PAD80_WORD = 64'h8000_0000_0000_0000;

    state_t            state, state_next;
    logic [511:0]      chunk_r;
    logic [2:0]        widx;
    logic [LEN_W-1:0]  byte_cnt, cnt_sum;
    logic              ovf;
    logic              pad80, len_done, msg_end, first_r;
    logic [3:0]        n_bytes, add;
    logic [63:0]       data_word, pad_word, len_word;
    logic              accept;

`ifdef SHA1_PADDER_LEN_CHECK_EN
    logic              len_err_r;
    assign {ovf, cnt_sum} = {1'b0, byte_cnt} + (LEN_W+1)'(add);
    assign in_ready = ~areset & ((state == S_DATA) | (state == S_DROP));
    assign len_err  = len_err_r;
`else
    assign cnt_sum  = byte_cnt + LEN_W'(add);
    assign ovf      = 1'b0;
    assign in_ready = ~areset & (state == S_DATA);
    assign len_err  = 1'b0;
`endif

    assign accept      = in_valid & in_ready;
    assign start       = (state == S_EMIT) & sink_ready;
    assign chunk       = chunk_r;
    assign chunk_first = (state == S_EMIT) & first_r;
    assign chunk_last  = (state == S_EMIT) & len_done;

    // Last-word masking: keep counted bytes, drop 0x80 right after them, zero the rest.
    always_comb begin
        n_bytes   = (in_bytes == 3'd0) ? 4'd8 : {1'b0, in_bytes};
        add       = in_last ? n_bytes : 4'd8;
        data_word = in_data;
        if (in_last && n_bytes != 4'd8) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) == n_bytes)
                    data_word[63-8*i -: 8] = 8'h80;
                else if (4'(i) > n_bytes)
                    data_word[63-8*i -: 8] = 8'h00;
            end
        end
        len_word = 64'(byte_cnt) << 3;
        if (widx == 3'd7)
            pad_word = pad80 ? len_word : PAD80_WORD;
        else
            pad_word = pad80 ? 64'd0 : PAD80_WORD;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_DATA: begin
                if (accept) begin
`ifdef SHA1_PADDER_LEN_CHECK_EN
                    if (ovf)
                        state_next = in_last ? S_DATA : S_DROP;
                    else
`endif
                    if (widx == 3'd7)
                        state_next = S_EMIT;
                    else if (in_last)
                        state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (widx == 3'd7)
                    state_next = S_EMIT;
            end
            S_EMIT: begin
                if (sink_ready)
                    state_next = (msg_end && !len_done) ? S_PAD : S_DATA;
            end
`ifdef SHA1_PADDER_LEN_CHECK_EN
            S_DROP: begin
                if (accept && in_last)
                    state_next = S_DATA;
            end
`endif
            default: state_next = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state    <= S_DATA;
            chunk_r  <= '0;
            widx     <= 3'd0;
            byte_cnt <= '0;
            pad80    <= 1'b0;
            len_done <= 1'b0;
            msg_end  <= 1'b0;
            first_r  <= 1'b1;
`ifdef SHA1_PADDER_LEN_CHECK_EN
            len_err_r <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef SHA1_PADDER_LEN_CHECK_EN
            len_err_r <= 1'b0;
`endif
            case (state)
                S_DATA: begin
                    if (accept) begin
                        if (ovf) begin
`ifdef SHA1_PADDER_LEN_CHECK_EN
                            len_err_r <= 1'b1;
`endif
                            widx     <= 3'd0;
                            byte_cnt <= '0;
                            pad80    <= 1'b0;
                            len_done <= 1'b0;
                            msg_end  <= 1'b0;
                            first_r  <= 1'b1;
                        end else begin
                            chunk_r[{~widx, 6'd0} +: 64] <= data_word;
                            byte_cnt <= cnt_sum;
                            widx     <= widx + 3'd1;
                            if (in_last) begin
                                msg_end <= 1'b1;
                                if (n_bytes != 4'd8)
                                    pad80 <= 1'b1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    chunk_r[{~widx, 6'd0} +: 64] <= pad_word;
                    widx <= widx + 3'd1;
                    if (!pad80)
                        pad80 <= 1'b1;
                    else if (widx == 3'd7)
                        len_done <= 1'b1;
                end
                S_EMIT: begin
                    if (sink_ready) begin
                        widx    <= 3'd0;
                        first_r <= 1'b0;
                        // Message fully emitted: re-arm for the next one.
                        if (msg_end && len_done) begin
                            byte_cnt <= '0;
                            pad80    <= 1'b0;
                            len_done <= 1'b0;
                            msg_end  <= 1'b0;
                            first_r  <= 1'b1;
                        end
                    end
                end
`ifdef SHA1_PADDER_LEN_CHECK_EN
                S_DROP: begin
                    if (accept && in_last) begin
                        widx     <= 3'd0;
                        byte_cnt <= '0;
                        pad80    <= 1'b0;
                        len_done <= 1'b0;
                        msg_end  <= 1'b0;
                        first_r  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// tb/tb_sha1_padder.sv - scoreboard bench for sha1_padder against a byte-level padding model.
module tb_sha1_padder;

`ifdef SHA1_PADDER_LEN_CHECK_EN
    localparam int LW = 8;
`else
    localparam int LW = 16;
`endif

    logic         clk = 1'b0;
    logic         areset;
    logic [63:0]  in_data;
    logic         in_valid, in_last;
    logic [2:0]   in_bytes;
    logic         in_ready, sink_ready, start;
    logic [511:0] chunk;
    logic         chunk_first, chunk_last, len_err;

    sha1_padder #(.LEN_W(LW)) dut (
        .clk(clk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
        .sink_ready(sink_ready), .start(start), .chunk(chunk),
        .chunk_first(chunk_first), .chunk_last(chunk_last), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] c;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         exp_q[$];
    byte unsigned msgq[$];
    int           start_cycs[$];
    int           n_cmp = 0, n_err = 0;
    int           cyc = 0, n_starts = 0, n_lenerr = 0, acc_cyc = 0;
    int           sink_mode = 1;
    logic [511:0] last_chunk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // 0: random, 1: held high, 2: held low
    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0: sink_ready = ($urandom % 4) != 0;
            1: sink_ready = 1'b1;
            default: sink_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (len_err) n_lenerr++;
        if (start) begin
            n_starts++;
            start_cycs.push_back(cyc);
            last_chunk = chunk;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 512'd1, 512'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("chunk", chunk, e.c);
                chk("chunk_first", chunk_first, e.f);
                chk("chunk_last", chunk_last, e.l);
            end
        end
    end

    // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_expected();
        byte unsigned p[$];
        longint unsigned bits;
        int nch;
        exp_t e;
        p = msgq;
        bits = 64'(msgq.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
        nch = p.size() / 64;
        for (int c = 0; c < nch; c++) begin
            for (int i = 0; i < 64; i++) e.c[511-8*i -: 8] = p[64*c+i];
            e.f = (c == 0);
            e.l = (c == nch - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic l, input logic [2:0] b);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                chk("in_ready_timeout", 512'd0, 512'd1);
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input bit gaps, input int nw_limit);
        int L, nw;
        logic [63:0] d;
        L = msgq.size();
        nw = (L + 7) / 8;
        if (nw_limit > 0 && nw_limit < nw) nw = nw_limit;
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < 8; i++)
                d[63-8*i -: 8] = (8*w + i < L) ? msgq[8*w+i] : 8'($urandom);
            if (w == (L + 7) / 8 - 1)
                send_word(d, 1'b1, 3'(L % 8));
            else
                send_word(d, 1'b0, 3'($urandom));
            if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic load_str(input string s);
        msgq.delete();
        for (int i = 0; i < s.len(); i++) msgq.push_back(s[i]);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); t++; end
        if (exp_q.size() != 0) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] abc_exp, held;
        int s0, e0;
        bit ok;
        int lens[$] = '{55, 56, 57, 63, 64, 65, 119, 120, 121, 127, 128, 1, 8, 9};

        areset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
        sink_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_chunk", chunk, 512'd0);
        chk("rst_first", chunk_first, 1'b0);
        chk("rst_last", chunk_last, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        @(posedge clk); #1;
        areset = 1'b0;

        abc_exp = '0;
        abc_exp[511:480] = 32'h6162_6380;
        abc_exp[63:0] = 64'h18;

        // "abc": single chunk, start 8 cycles after the last word
        load_str("abc"); build_expected(); start_cycs.delete();
        send_msg(1'b0, 0); drain();
        chk("abc_literal", last_chunk, abc_exp);
        chk("abc_latency", 512'(start_cycs[0] - acc_cyc), 512'd8);

        // 56-byte FIPS message: length spills into a second chunk
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        build_expected(); send_msg(1'b0, 0); drain();
        chk("fips56_word7", last_chunk[63:0], 64'h1C0);

        // 64 bytes: full chunk emitted the cycle after word 7
        msgq.delete();
        for (int i = 0; i < 64; i++) msgq.push_back(8'($urandom));
        build_expected(); start_cycs.delete();
        send_msg(1'b0, 0);
        drain();
        chk("full_latency", 512'(start_cycs[0] - acc_cyc), 512'd1);
        chk("m64_chunkB", last_chunk, {64'h8000_0000_0000_0000, 384'd0, 64'h200});

        // Backpressure in EMIT
        sink_mode = 2;
        load_str("abc"); build_expected();
        send_msg(1'b0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        held = chunk; s0 = n_starts; ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || start !== 1'b0 || chunk !== held) ok = 1'b0;
        end
        chk("bp_hold", ok, 1'b1);
        chk("bp_chunk", held, abc_exp);
        sink_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_one_start", 512'(n_starts - s0), 512'd1);
        drain();

        // Reset after 3 words discards the partial chunk
        msgq.delete();
        for (int i = 0; i < 40; i++) msgq.push_back(8'($urandom));
        s0 = n_starts;
        send_msg(1'b0, 3);
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1; areset = 1'b0;
        chk("rst_mid_chunk", chunk, 512'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_nostart", 512'(n_starts - s0), 512'd0);
        load_str("abc"); build_expected(); send_msg(1'b0, 0); drain();
        chk("rst_abc", last_chunk, abc_exp);

        // Boundary lengths then random lengths, random gaps and sink stalls
        sink_mode = 0;
        repeat (20) lens.push_back(int'($urandom_range(200, 1)));
        foreach (lens[k]) begin
            msgq.delete();
            for (int i = 0; i < lens[k]; i++) msgq.push_back(8'($urandom));
            build_expected();
            send_msg(1'b1, 0);
        end
        drain();
        sink_mode = 1;

`ifdef SHA1_PADDER_LEN_CHECK_EN
        // 264 bytes with LEN_W=8: three chunks stand, then overflow drops the rest
        msgq.delete();
        for (int i = 0; i < 264; i++) msgq.push_back(8'($urandom));
        for (int c = 0; c < 3; c++) begin
            exp_t e;
            for (int i = 0; i < 64; i++) e.c[511-8*i -: 8] = msgq[64*c+i];
            e.f = (c == 0);
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        e0 = n_lenerr; s0 = n_starts;
        send_msg(1'b0, 0);
        drain();
        chk("ovf_len_err", 512'(n_lenerr - e0), 512'd1);
        chk("ovf_starts", 512'(n_starts - s0), 512'd3);
        load_str("abc"); build_expected(); send_msg(1'b0, 0); drain();
        chk("ovf_abc", last_chunk, abc_exp);
`else
        e0 = n_lenerr;
        chk("len_err_tied", 512'(e0), 512'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha1_padder.md
# sha1_padder

Upstream feeder for `sha1_pipe`. It accepts an NTP MAC message as a stream of 64-bit big-endian words and packs it into 512-bit SHA-1 chunks. It applies FIPS 180-2 padding: a 0x80 byte, zero fill, then a 64-bit big-endian bit length. Each completed chunk is issued to `sha1_pipe` with a one-cycle `start`, gated by the pipe's `in_ready`; first/last flags let the chaining logic select IV or previous digest.

## Interface
- `LEN_W`, default 16: width of the message byte counter. Maximum message length is 2^LEN_W−1 bytes.
- `clk`  in  1: single clock; everything is on its rising edge.
- `areset`  in  1: synchronous, active-high reset.
- `in_data`  in  64: message word; first byte in [63:56].
- `in_valid`  in  1: `in_data` is valid.
- `in_last`  in  1: final word of the message.
- `in_bytes`  in  3: valid bytes in the last word. 0 means 8. Ignored unless `in_last`.
- `in_ready`  out  1: word is accepted on an edge with `in_valid & in_ready`.
- `sink_ready`  in  1: connect to `sha1_pipe.in_ready`.
- `start`  out  1: one-cycle chunk strobe; connect to `sha1_pipe.start`.
- `chunk`  out  512: chunk; word 0 at [511:448].
- `chunk_first`  out  1: chunk is the first of its message. Valid while `start`.
- `chunk_last`  out  1: chunk is the last of its message. Valid while `start`.
- `len_err`  out  1: length-overflow pulse. Tied 0 without the macro.

## Operation
- Chunk register holds 8 words; `widx` (0..7) is the next word to write.
- State DATA: `in_ready = ~areset`.
  - An accepted word is written at `widx`.
  - The byte counter is incremented by 8, or by `in_bytes` (0→8) on the last word.
  - On the last word with fewer than 8 bytes: bytes past the count are forced to 0, and 0x80 is placed at the first unused byte; set `pad80`.
  - Not last and `widx==7` → EMIT. Last and `widx==7` → EMIT with `tail=1`. Last and `widx<7` → PAD.
- State PAD: one word written per cycle at `widx`.
  - Word 7 gets `{bytecount*8}` zero-extended to 64 bits, only if `pad80` was set at a word index ≤6 of this chunk; otherwise word 7 is zero.
  - Any other word gets 0x80000000_00000000 if `pad80` is clear (then set `pad80`), else zero.
  - After word 7 → EMIT.
- State EMIT: `in_ready=0`; chunk held stable.
  - `start = (state==EMIT) & sink_ready`, combinational.
  - On the start edge: `chunk_first` clears.
  - If the message continues → DATA with `widx=0`.
  - If the length is not yet written → PAD with `widx=0`; this is the extra-chunk case when data ended at byte ≥56.
  - Otherwise → DATA, and `chunk_first`, the byte counter and `pad80` are re-armed for the next message.
- `chunk_last` is 1 in EMIT exactly when the length word is in the chunk.
- Length boundary rules:
  - 0x80 lands in word ≤6 → single final chunk.
  - 0x80 lands in word 7, or data fills word 7 with fewer than 8 bytes → a second chunk of zeros plus length.
  - Data ends exactly at word 7 full → next chunk is 0x80 word, zeros, length.
- Empty message (`in_last` with `in_bytes` treated as 0 bytes) is not supported; upstream never sends it.

## Timing
- Reset values: `start=0`, `in_ready=0` during reset, `chunk=0`, `chunk_first=0`, `chunk_last=0`, `len_err=0`; state DATA, `widx=0`, counters 0.
- Reset mid-message discards the partial chunk; no `start` is issued for it.
- Last word accepted in cycle k at `widx=w<7` → PAD for cycles k+1..k+7−w. `start` is possible from cycle k+8−w.
- Full chunk (`widx=7` accepted in cycle k) → `start` is possible in cycle k+1.
- `sink_ready` low in EMIT holds everything. No input is accepted until `start` fires.
- Peak throughput is 8 data words + 1 EMIT cycle per chunk, within `sha1_pipe`'s 10-cycle acceptance interval.

## Configuration
- `SHA1_PADDER_LEN_CHECK_EN` defined:
  - When an accepted word would push the byte count above 2^LEN_W−1, `len_err` pulses for one cycle.
  - The partial chunk is dropped and the block enters DROP. In DROP, `in_ready=1` and words are consumed with no `start`.
  - `in_last` in DROP returns the block to DATA, re-armed for a new message.
  - Chunks already issued stand; downstream discards the digest on `len_err`.
- Not defined: the counter wraps modulo 2^LEN_W, `len_err` is tied 0, and there is no DROP state.

## Test plan
- "abc": one word 0x61626300_00000000, last, `in_bytes=3` → one `start` in cycle k+8; `chunk` = 61626380 followed by zeros and 0x…00000018; first=1, last=1.
- 56-byte FIPS message "abcdbcdecdef…nopq", 7 full words, last → chunk A = data words with word 7 = 80000000_00000000, first=1 last=0. Chunk B = zeros with word 7 = 0x1C0, first=0 last=1.
- 64-byte message of 8 full words → chunk A = data, first=1 last=0. Chunk B = word 0 0x80000000_00000000, word 7 0x200, last=1.
- Backpressure: hold `sink_ready=0` for 20 cycles in EMIT → `in_ready=0`, `chunk` stable, exactly one `start` on the cycle `sink_ready` returns.
- `areset` pulse after 3 words of a message → no `start`. A following "abc" yields the exact chunk of scenario 1 with first=1.
- Macro defined, `LEN_W=8`, 33 full words (264 bytes) → `len_err` pulse on word 32, no further `start`. The next "abc" is correct.
